// File: rtl/car_parking_system.sv
// ---------------------------------------------------------------------------
// car_parking_system
//   Gate controller for a single-lane car park entrance. A car arriving at
//   the entrance sensor is held until the keypad shows the password. On a
//   match the gate opens (Green). Once the car reaches the exit sensor the
//   controller returns to idle. If a second car is already waiting while the
//   first one exits, the controller parks in STOP until that car enters the
//   password.
//
// Ports
//   CLOCK      in   1  system clock, rising edge
//   RESET      in   1  synchronous, active-high reset
//   Entrance   in   1  car present at entrance sensor
//   Exit       in   1  car present at exit sensor (passing the gate)
//   PASSWORD   in   4  keypad value, sampled every rising edge
//   Green      out  1  gate-open LED
//   Red        out  1  gate-closed / alert LED
//   INDICATOR  out  3  current state code
// ---------------------------------------------------------------------------
module car_parking_system #(
  parameter logic [3:0] PASSWORD_KEY = 4'b1011
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       Entrance,
  input  logic       Exit,
  input  logic [3:0] PASSWORD,
  output logic       Green,
  output logic       Red,
  output logic [2:0] INDICATOR
);

  typedef enum logic [2:0] {
    IDLE       = 3'b000,
    HOLD       = 3'b001,
    WRONG_PASS = 3'b010,
    RIGHT_PASS = 3'b011,
    STOP       = 3'b100
  } state_t;

  state_t state_reg;
  state_t state_next;
  logic   green_next;
  logic   red_next;
  logic   match;

  assign match = (PASSWORD == PASSWORD_KEY);

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:       state_next = Entrance ? HOLD : IDLE;
      HOLD:       state_next = match ? RIGHT_PASS : WRONG_PASS;
      WRONG_PASS: state_next = match ? RIGHT_PASS : WRONG_PASS;
      RIGHT_PASS: begin
        if (Entrance && Exit)
          state_next = STOP;
        else if (Exit)
          state_next = IDLE;
        else
          state_next = RIGHT_PASS;
      end
      STOP:       state_next = match ? RIGHT_PASS : STOP;
      // Codes 101..111 are unreachable in normal operation; recover to IDLE.
      default:    state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered and registered alongside
  // it, so Red/Green always line up with INDICATOR and carry no input paths
  // at the module boundary.
  always_comb begin
    green_next = 1'b0;
    red_next   = 1'b0;
    case (state_next)
      HOLD, WRONG_PASS, STOP: red_next   = 1'b1;
      RIGHT_PASS:             green_next = 1'b1;
      default: begin
        green_next = 1'b0;
        red_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_reg <= IDLE;
      Green     <= 1'b0;
      Red       <= 1'b0;
    end else begin
      state_reg <= state_next;
      Green     <= green_next;
      Red       <= red_next;
    end
  end

  assign INDICATOR = state_reg;

endmodule

// File: tb/tb_car_parking_system.sv
// ---------------------------------------------------------------------------
// tb_car_parking_system
//   Directed walk through the gate scenarios with literal expectations, then
//   randomized sensor/keypad/reset traffic compared every cycle against a
//   behavioural model of the gate controller.
// ---------------------------------------------------------------------------
module tb_car_parking_system;

  localparam logic [3:0] KEY = 4'b1011;

  // State codes as seen on INDICATOR.
  localparam int S_IDLE  = 0;
  localparam int S_HOLD  = 1;
  localparam int S_WRONG = 2;
  localparam int S_RIGHT = 3;
  localparam int S_STOP  = 4;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       Entrance = 1'b0;
  logic       Exit = 1'b0;
  logic [3:0] PASSWORD = 4'b0000;
  logic       Green;
  logic       Red;
  logic [2:0] INDICATOR;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int model_state = S_IDLE;

  // Lamp colours per state: idle dark, open green, every waiting state red.
  bit red_of   [5] = '{0, 1, 1, 0, 1};
  bit green_of [5] = '{0, 0, 0, 1, 0};

  car_parking_system #(.PASSWORD_KEY(KEY)) dut (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .Entrance (Entrance),
    .Exit     (Exit),
    .PASSWORD (PASSWORD),
    .Green    (Green),
    .Red      (Red),
    .INDICATOR(INDICATOR)
  );

  always #5 CLOCK = ~CLOCK;

  // Gate behaviour: every "waiting for a code" state opens on the right code;
  // a fresh car given a wrong code drops into the retry state, the others
  // just keep waiting. An open gate closes behind a leaving car unless
  // another car is already at the entrance.
  function automatic int model_next(int s, bit rst, bit ent, bit ext, logic [3:0] pw);
    bit waiting_for_code;
    if (rst) return S_IDLE;
    waiting_for_code = (s == S_HOLD) || (s == S_WRONG) || (s == S_STOP);
    if (waiting_for_code) begin
      if (pw == KEY) return S_RIGHT;
      return (s == S_HOLD) ? S_WRONG : s;
    end
    if (s == S_RIGHT) begin
      if (!ext) return S_RIGHT;
      return ent ? S_STOP : S_IDLE;
    end
    return ent ? S_HOLD : S_IDLE;
  endfunction

  task automatic check(string name, logic [2:0] act, logic [2:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
  endtask

  // One clock: apply inputs, advance the model on the edge, then compare the
  // DUT against the model on the following falling edge.
  task automatic step(bit rst, bit ent, bit ext, logic [3:0] pw);
    RESET    = rst;
    Entrance = ent;
    Exit     = ext;
    PASSWORD = pw;
    @(posedge CLOCK);
    model_state = model_next(model_state, rst, ent, ext, pw);
    @(negedge CLOCK);
    check("indicator", INDICATOR, 3'(model_state));
    check("red",       {2'b00, Red},   {2'b00, red_of[model_state]});
    check("green",     {2'b00, Green}, {2'b00, green_of[model_state]});
  endtask

  // Directed step plus literal expectations that pin the model itself.
  task automatic dstep(string name, bit rst, bit ent, bit ext, logic [3:0] pw,
                       logic [2:0] exp_ind, bit exp_red, bit exp_green);
    step(rst, ent, ext, pw);
    $display("step %-12s rst=%0b ent=%0b exit=%0b pw=%4b -> ind=%3b red=%0b green=%0b",
             name, rst, ent, ext, pw, INDICATOR, Red, Green);
    check({name, "_ind"},   INDICATOR, exp_ind);
    check({name, "_red"},   {2'b00, Red},   {2'b00, exp_red});
    check({name, "_green"}, {2'b00, Green}, {2'b00, exp_green});
  endtask

  task automatic directed_pass();
    dstep("idle",      0, 0, 0, 4'b1001, 3'b000, 0, 0);
    dstep("hold",      0, 1, 0, 4'b1111, 3'b001, 1, 0);
    dstep("wrong",     0, 1, 0, 4'b1000, 3'b010, 1, 0);
    dstep("wrong_stay",0, 1, 0, 4'b1100, 3'b010, 1, 0);
    dstep("right",     0, 0, 0, 4'b1011, 3'b011, 0, 1);
    dstep("exit_idle", 0, 0, 1, 4'b0000, 3'b000, 0, 0);
    dstep("idle_exit", 0, 0, 1, 4'b1011, 3'b000, 0, 0);
    dstep("hold2",     0, 1, 0, 4'b0000, 3'b001, 1, 0);
    dstep("hold_right",0, 1, 1, 4'b1011, 3'b011, 0, 1);
    dstep("right_stay",0, 1, 0, 4'b0000, 3'b011, 0, 1);
    dstep("stop",      0, 1, 1, 4'b0000, 3'b100, 1, 0);
    dstep("stop_stay", 0, 1, 1, 4'b1111, 3'b100, 1, 0);
    dstep("stop_right",0, 0, 0, 4'b1011, 3'b011, 0, 1);
    dstep("stop2",     0, 1, 1, 4'b0101, 3'b100, 1, 0);
    dstep("reset_mid", 1, 1, 1, 4'b1011, 3'b000, 0, 0);
  endtask

  initial begin
    // Reset state with non-quiet inputs: reset must win.
    RESET = 1'b1; Entrance = 1'b1; Exit = 1'b1; PASSWORD = KEY;
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    model_state = S_IDLE;
    check("reset_ind",   INDICATOR, 3'b000);
    check("reset_red",   {2'b00, Red},   3'b000);
    check("reset_green", {2'b00, Green}, 3'b000);

    directed_pass();
    directed_pass();   // the sequence must repeat identically after reset

    // Randomized traffic; the correct code is biased up so the gate opens often.
    for (int i = 0; i < 3000; i++) begin
      bit         r_rst;
      bit         r_ent;
      bit         r_ext;
      logic [3:0] r_pw;
      r_rst = ($urandom_range(0, 59) == 0);
      r_ent = $urandom_range(0, 1) == 1;
      r_ext = $urandom_range(0, 2) == 0;
      r_pw  = ($urandom_range(0, 2) == 0) ? KEY : 4'($urandom_range(0, 15));
      step(r_rst, r_ent, r_ext, r_pw);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
